// File: rtl/coin_acceptor_if.sv
`default_nettype none
// ============================================================================
// Module      : coin_acceptor_if
// Description : Handshake bundle between the vending controller/coin
//               mechanism (master) and the coin acceptor (slave).
//               Master drives: open_session, close_session, clear,
//                              coin_valid, coin_type[1:0]
//               Slave drives : coin_accept, coin_reject, dinheiro_inserido,
//                              moedas_inseridas_25/50/100, total_valid,
//                              busy, timeout
// Revision    : 1.0 - initial release
// ============================================================================
interface coin_acceptor_if;
    logic       open_session;
    logic       close_session;
    logic       clear;
    logic       coin_valid;
    logic [1:0] coin_type;

    logic       coin_accept;
    logic       coin_reject;
    logic [7:0] dinheiro_inserido;
    logic [7:0] moedas_inseridas_25;
    logic [7:0] moedas_inseridas_50;
    logic [7:0] moedas_inseridas_100;
    logic       total_valid;
    logic       busy;
    logic       timeout;

    modport master (
        output open_session, close_session, clear, coin_valid, coin_type,
        input  coin_accept, coin_reject, dinheiro_inserido,
               moedas_inseridas_25, moedas_inseridas_50, moedas_inseridas_100,
               total_valid, busy, timeout
    );

    modport slave (
        input  open_session, close_session, clear, coin_valid, coin_type,
        output coin_accept, coin_reject, dinheiro_inserido,
               moedas_inseridas_25, moedas_inseridas_50, moedas_inseridas_100,
               total_valid, busy, timeout
    );
endinterface
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : coin_acceptor
// Description : Session-based coin validator. Accepts coin strobes while a
//               purchase session is collecting, keeps the session total in
//               cents and a count per coin type, and holds the result until
//               the controller clears it. All outputs are registered.
// Ports       : clock - rising-edge clock
//               reset - asynchronous active-high reset
//               bus   - coin_acceptor_if.slave (session control, coin strobe,
//                       accept/reject pulses, totals, status flags)
// Revision    : 1.0 - initial release
// ============================================================================
module coin_acceptor #(
    parameter int MAX_TOTAL      = 250,   // session cap in cents, <= 255
    parameter int TIMEOUT_CYCLES = 1000,  // idle COLLECT cycles before close
    parameter int TW             = 10     // 2**TW > TIMEOUT_CYCLES
) (
    input  logic            clock,
    input  logic            reset,
    coin_acceptor_if.slave  bus
);

    localparam logic [8:0]    c_max_total = 9'(MAX_TOTAL);
    localparam logic [TW-1:0] c_timeout   = TW'(TIMEOUT_CYCLES);
    localparam logic [1:0]    c_type_bad  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HELD    = 2'd2
    } state_t;

    state_t        r_state;
    logic [7:0]    r_total;
    logic [7:0]    r_cnt_25;
    logic [7:0]    r_cnt_50;
    logic [7:0]    r_cnt_100;
    logic [TW-1:0] r_timer;
    logic          r_accept;
    logic          r_reject;
    logic          r_timeout;
    logic          r_total_valid;
    logic          r_busy;

    logic [7:0]    w_coin_value;
    logic [8:0]    w_sum;
    logic          w_fits;
    logic [TW-1:0] w_timer_next;
    logic          w_timer_hit;

    always_comb begin
        w_coin_value = 8'd0;
        case (bus.coin_type)
            2'd0:    w_coin_value = 8'd25;
            2'd1:    w_coin_value = 8'd50;
            2'd2:    w_coin_value = 8'd100;
            default: w_coin_value = 8'd0;
        endcase
    end

    // Nine-bit sum so that an overflowing coin is caught rather than wrapped.
    assign w_sum        = {1'b0, r_total} + {1'b0, w_coin_value};
    assign w_fits       = (w_sum <= c_max_total);
    assign w_timer_next = r_timer + 1'b1;
    assign w_timer_hit  = (w_timer_next == c_timeout);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_total       <= 8'd0;
            r_cnt_25      <= 8'd0;
            r_cnt_50      <= 8'd0;
            r_cnt_100     <= 8'd0;
            r_timer       <= '0;
            r_accept      <= 1'b0;
            r_reject      <= 1'b0;
            r_timeout     <= 1'b0;
            r_total_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_accept  <= 1'b0;
            r_reject  <= 1'b0;
            r_timeout <= 1'b0;

            if (bus.clear) begin
                // Abort/consume: a coin on this edge goes back to the customer.
                r_reject      <= bus.coin_valid;
                r_state       <= S_IDLE;
                r_total       <= 8'd0;
                r_cnt_25      <= 8'd0;
                r_cnt_50      <= 8'd0;
                r_cnt_100     <= 8'd0;
                r_timer       <= '0;
                r_total_valid <= 1'b0;
                r_busy        <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_reject <= bus.coin_valid;
                        if (bus.open_session) begin
                            r_state <= S_COLLECT;
                            r_timer <= '0;
                            r_busy  <= 1'b1;
                        end
                    end

                    S_COLLECT: begin
                        if (bus.coin_valid) begin
                            r_timer <= '0;
                            if ((bus.coin_type == c_type_bad) || !w_fits) begin
                                r_reject <= 1'b1;
                            end else begin
                                r_accept <= 1'b1;
                                r_total  <= w_sum[7:0];
                                case (bus.coin_type)
                                    2'd0:    r_cnt_25  <= r_cnt_25 + 8'd1;
                                    2'd1:    r_cnt_50  <= r_cnt_50 + 8'd1;
                                    default: r_cnt_100 <= r_cnt_100 + 8'd1;
                                endcase
                            end
                        end else begin
                            r_timer <= w_timer_next;
                        end

                        // The coin above is already folded into the result
                        // that is about to be held.
                        if (bus.close_session) begin
                            r_state       <= S_HELD;
                            r_timer       <= '0;
                            r_total_valid <= 1'b1;
                        end else if (!bus.coin_valid && w_timer_hit) begin
                            r_timeout <= 1'b1;
                            r_timer   <= '0;
                            if (r_total != 8'd0) begin
                                r_state       <= S_HELD;
                                r_total_valid <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end

                    S_HELD: begin
                        r_reject <= bus.coin_valid;
                    end

                    default: begin
                        r_state       <= S_IDLE;
                        r_total_valid <= 1'b0;
                        r_busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.coin_accept          = r_accept;
    assign bus.coin_reject          = r_reject;
    assign bus.dinheiro_inserido    = r_total;
    assign bus.moedas_inseridas_25  = r_cnt_25;
    assign bus.moedas_inseridas_50  = r_cnt_50;
    assign bus.moedas_inseridas_100 = r_cnt_100;
    assign bus.total_valid          = r_total_valid;
    assign bus.busy                 = r_busy;
    assign bus.timeout              = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_acceptor
// Description : Self-checking bench for coin_acceptor. A session-level model
//               predicts every registered output each cycle; directed
//               scenarios add literal expectations, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_acceptor;

    localparam int MAX_TOTAL      = 250;
    localparam int TIMEOUT_CYCLES = 1000;

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_HELD    = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    coin_acceptor_if bus ();

    coin_acceptor #(
        .MAX_TOTAL      (MAX_TOTAL),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TW             (10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- session-level model ----------------
    int m_mode  = M_IDLE;
    int m_total = 0;
    int m_cnt[3] = '{0, 0, 0};
    int m_quiet = 0;     // COLLECT edges since entry or last coin
    bit e_acc = 0, e_rej = 0, e_to = 0;

    function automatic int coin_cents(input int t);
        return 25 * (1 << t);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_total = 0; m_cnt = '{0, 0, 0}; m_quiet = 0;
        e_acc = 0; e_rej = 0; e_to = 0;
    endtask

    task automatic model_step(input bit op, input bit cl, input bit clr,
                              input bit cv, input int ct);
        e_acc = 0; e_rej = 0; e_to = 0;
        if (clr) begin
            e_rej = cv;
            m_mode = M_IDLE; m_total = 0; m_cnt = '{0, 0, 0}; m_quiet = 0;
        end else if (m_mode == M_IDLE) begin
            e_rej = cv;
            if (op) begin m_mode = M_COLLECT; m_quiet = 0; end
        end else if (m_mode == M_COLLECT) begin
            if (cv) begin
                m_quiet = 0;
                if (ct == 3 || m_total + coin_cents(ct) > MAX_TOTAL) e_rej = 1;
                else begin
                    e_acc = 1;
                    m_total += coin_cents(ct);
                    m_cnt[ct]++;
                end
            end else m_quiet++;
            if (cl) m_mode = M_HELD;
            else if (!cv && m_quiet == TIMEOUT_CYCLES) begin
                e_to = 1;
                m_quiet = 0;
                m_mode = (m_total > 0) ? M_HELD : M_IDLE;
            end
        end else begin
            e_rej = cv;
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    initial begin
        forever begin
            @(posedge clock);
            if (reset) model_reset();
            else model_step(bus.open_session, bus.close_session, bus.clear,
                            bus.coin_valid, int'(bus.coin_type));
            #1;
            chk("cyc accept",  32'(bus.coin_accept), 32'(e_acc));
            chk("cyc reject",  32'(bus.coin_reject), 32'(e_rej));
            chk("cyc timeout", 32'(bus.timeout), 32'(e_to));
            chk("cyc total",   32'(bus.dinheiro_inserido), m_total);
            chk("cyc n25",     32'(bus.moedas_inseridas_25), m_cnt[0]);
            chk("cyc n50",     32'(bus.moedas_inseridas_50), m_cnt[1]);
            chk("cyc n100",    32'(bus.moedas_inseridas_100), m_cnt[2]);
            chk("cyc total_valid", 32'(bus.total_valid), 32'(m_mode == M_HELD));
            chk("cyc busy",    32'(bus.busy), 32'(m_mode != M_IDLE));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit op, input bit cl, input bit clr, input bit cv, input int ct);
        @(negedge clock);
        bus.open_session  = op;
        bus.close_session = cl;
        bus.clear         = clr;
        bus.coin_valid    = cv;
        bus.coin_type     = 2'(ct);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic look();
        @(posedge clock);
        #2;
    endtask

    task automatic coin(input int ct, input bit acc, input bit rej, input int tot);
        step(0, 0, 0, 1, ct);
        look();
        chk("coin accept", 32'(bus.coin_accept), 32'(acc));
        chk("coin reject", 32'(bus.coin_reject), 32'(rej));
        chk("coin total",  32'(bus.dinheiro_inserido), tot);
    endtask

    initial begin
        bus.open_session = 0; bus.close_session = 0; bus.clear = 0;
        bus.coin_valid = 0; bus.coin_type = 2'd0;
        repeat (2) @(negedge clock);
        reset = 0;

        // 1: asynchronous reset in the middle of a session
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2);
        idle_step();
        look();
        chk("t1 total before reset", 32'(bus.dinheiro_inserido), 100);
        reset = 1;
        #1;
        chk("t1 async total", 32'(bus.dinheiro_inserido), 0);
        chk("t1 async n100",  32'(bus.moedas_inseridas_100), 0);
        chk("t1 async busy",  32'(bus.busy), 0);
        chk("t1 async total_valid", 32'(bus.total_valid), 0);
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        look();
        chk("t1 busy after release", 32'(bus.busy), 0);

        // 2: one coin of each type, then close
        step(1, 0, 0, 0, 0);
        coin(0, 1, 0, 25);
        coin(1, 1, 0, 75);
        coin(2, 1, 0, 175);
        step(0, 1, 0, 0, 0);
        look();
        chk("t2 total_valid", 32'(bus.total_valid), 1);
        chk("t2 total", 32'(bus.dinheiro_inserido), 175);
        chk("t2 n25",  32'(bus.moedas_inseridas_25), 1);
        chk("t2 n50",  32'(bus.moedas_inseridas_50), 1);
        chk("t2 n100", 32'(bus.moedas_inseridas_100), 1);
        step(0, 0, 1, 0, 0);

        // 3: cap at MAX_TOTAL
        step(1, 0, 0, 0, 0);
        coin(2, 1, 0, 100);
        coin(2, 1, 0, 200);
        coin(2, 0, 1, 200);
        coin(1, 1, 0, 250);
        coin(0, 0, 1, 250);
        chk("t3 n100", 32'(bus.moedas_inseridas_100), 2);
        chk("t3 n25",  32'(bus.moedas_inseridas_25), 0);
        step(0, 0, 1, 0, 0);

        // 4: invalid type, coin in IDLE, coin in HELD
        coin(0, 0, 1, 0);
        chk("t4 idle busy", 32'(bus.busy), 0);
        step(1, 0, 0, 0, 0);
        coin(3, 0, 1, 0);
        chk("t4 bad n25", 32'(bus.moedas_inseridas_25), 0);
        coin(0, 1, 0, 25);
        step(0, 1, 0, 0, 0);
        coin(1, 0, 1, 25);
        chk("t4 held total_valid", 32'(bus.total_valid), 1);
        chk("t4 held n50", 32'(bus.moedas_inseridas_50), 0);
        step(0, 0, 1, 0, 0);

        // 5a: empty session times out to IDLE
        step(1, 0, 0, 0, 0);
        repeat (TIMEOUT_CYCLES - 1) idle_step();
        look();
        chk("t5a pre timeout", 32'(bus.timeout), 0);
        chk("t5a pre busy",    32'(bus.busy), 1);
        idle_step();
        look();
        chk("t5a timeout", 32'(bus.timeout), 1);
        chk("t5a busy",    32'(bus.busy), 0);

        // 5b: 75c session times out to HELD
        step(1, 0, 0, 0, 0);
        coin(0, 1, 0, 25);
        coin(1, 1, 0, 75);
        repeat (TIMEOUT_CYCLES - 1) idle_step();
        look();
        chk("t5b pre timeout", 32'(bus.timeout), 0);
        idle_step();
        look();
        chk("t5b timeout", 32'(bus.timeout), 1);
        chk("t5b total_valid", 32'(bus.total_valid), 1);
        chk("t5b total", 32'(bus.dinheiro_inserido), 75);
        step(0, 0, 1, 0, 0);

        // 6: coin and close together, then clear
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1);
        look();
        chk("t6 accept", 32'(bus.coin_accept), 1);
        chk("t6 total", 32'(bus.dinheiro_inserido), 50);
        chk("t6 total_valid", 32'(bus.total_valid), 1);
        step(0, 0, 1, 0, 0);
        look();
        chk("t6 clr total", 32'(bus.dinheiro_inserido), 0);
        chk("t6 clr n50",   32'(bus.moedas_inseridas_50), 0);
        chk("t6 clr busy",  32'(bus.busy), 0);

        // random traffic against the model
        repeat (4000) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 3)));
        end

        idle_step();
        look();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
